// File: rtl/cv32e40p_clock_gate_ctrl.sv
// Multi-channel clock-gate controller: per-channel hysteresis FSM driving a latch-based glitch-free gate.
// Optional per-channel gated-cycle statistics counters are built when CLOCK_GATE_STATS_EN is defined.
module cv32e40p_clock_gate_ctrl #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned IDLE_CYCLES = 8,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NUM_CH-1:0] en_i,
    input  logic              test_en_i,
    output logic [NUM_CH-1:0] clk_o,
    output logic [NUM_CH-1:0] gated_o,
    output logic              all_gated_o
`ifdef CLOCK_GATE_STATS_EN
    ,
    output logic [NUM_CH*CNT_W-1:0] gated_cnt_o
`endif
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        GATED = 2'd2
    } state_e;

    localparam logic [7:0] IDLE_V  = 8'(IDLE_CYCLES);
    localparam logic [7:0] IDLE_M1 = IDLE_V - 8'd1;

    genvar c;
    for (c = 0; c < NUM_CH; c++) begin : g_ch
        state_e     state_q, state_d;
        logic [7:0] cnt_q, cnt_d;
        logic       en_q, en_d;
        logic       gated_q, gated_d;
        logic       latchEn;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            unique case (state_q)
                RUN: begin
                    if (!en_i[c]) begin
                        if (IDLE_CYCLES == 0) begin
                            state_d = GATED;
                        end else begin
                            state_d = DRAIN;
                            cnt_d   = IDLE_M1;
                        end
                    end
                end
                DRAIN: begin
                    if (en_i[c]) begin
                        state_d = RUN;
                        cnt_d   = IDLE_V;
                    end else if (cnt_q == 8'd0) begin
                        state_d = GATED;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                GATED: begin
                    if (en_i[c]) begin
                        state_d = RUN;
                        cnt_d   = IDLE_V;
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = IDLE_V;
                end
            endcase
            en_d    = (state_d != GATED);
            gated_d = (state_d == GATED);
        end

        // Reset keeps the gate open so downstream synchronous resets still see clock edges.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q <= RUN;
                cnt_q   <= IDLE_V;
                en_q    <= 1'b1;
                gated_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                en_q    <= en_d;
                gated_q <= gated_d;
            end
        end

        // Enable only changes while clk_i is low, so high phases are never truncated.
        always_latch begin
            if (!clk_i) begin
                latchEn = en_q | test_en_i;
            end
        end

        assign clk_o[c]   = clk_i & latchEn;
        assign gated_o[c] = gated_q;

`ifdef CLOCK_GATE_STATS_EN
        logic [CNT_W-1:0] statCnt_q;

        // Saturating count of edges taken while the channel sat in GATED.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                statCnt_q <= '0;
            end else if ((state_q == GATED) && (statCnt_q != {CNT_W{1'b1}})) begin
                statCnt_q <= statCnt_q + CNT_W'(1);
            end
        end

        assign gated_cnt_o[c*CNT_W +: CNT_W] = statCnt_q;
`else
        if (CNT_W == 0) begin : g_no_stats
        end
`endif
    end

    assign all_gated_o = &gated_o;

endmodule

// File: tb/tb_cv32e40p_clock_gate_ctrl.sv
// Scoreboard bench for cv32e40p_clock_gate_ctrl (4 channels, 8 idle cycles).
// Expectations are absolute cycle numbers; the monitor compares them 1 time unit after each rising edge.
module tb_cv32e40p_clock_gate_ctrl;

    localparam int NUM_CH = 4;
    localparam int IDLE   = 8;
    localparam int CNT_W  = 4;

    typedef struct {
        int          cyc;
        bit          isCnt;
        logic [3:0]  clk;
        logic [3:0]  gated;
        logic [15:0] cnt;
        string       name;
    } exp_t;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       test_en_i;
    logic [3:0] en_i;
    logic [3:0] clk_o;
    logic [3:0] gated_o;
    logic       all_gated_o;
`ifdef CLOCK_GATE_STATS_EN
    logic [15:0] gated_cnt_o;
`endif

    int   cyc         = 0;
    int   testsRun    = 0;
    int   testsFailed = 0;
    exp_t q[$];

    cv32e40p_clock_gate_ctrl #(
        .NUM_CH     (NUM_CH),
        .IDLE_CYCLES(IDLE),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (en_i),
        .test_en_i  (test_en_i),
        .clk_o      (clk_o),
        .gated_o    (gated_o),
        .all_gated_o(all_gated_o)
`ifdef CLOCK_GATE_STATS_EN
        ,
        .gated_cnt_o(gated_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Queue an expected pin state for an absolute cycle.
    task automatic expectAt(input int c, input logic [3:0] ck, input logic [3:0] g, input string name);
        exp_t e;
        e.cyc   = c;
        e.isCnt = 1'b0;
        e.clk   = ck;
        e.gated = g;
        e.cnt   = 16'h0;
        e.name  = name;
        q.push_back(e);
    endtask

    // Queue an expected statistics value (same value in every channel).
    task automatic expectCnt(input int c, input logic [3:0] v, input string name);
        exp_t e;
        e.cyc   = c;
        e.isCnt = 1'b1;
        e.clk   = 4'h0;
        e.gated = 4'h0;
        e.cnt   = {4{v}};
        e.name  = name;
        q.push_back(e);
    endtask

    // Drive inputs in the low phase right after rising edge k.
    task automatic applyStimulus(input int k, input logic r, input logic [3:0] e, input logic t);
        while (cyc < k) @(negedge clk_i);
        rst_i     = r;
        en_i      = e;
        test_en_i = t;
    endtask

    // Compare one scoreboard entry against the sampled outputs.
    task automatic checkOutput(input exp_t e);
        if (e.isCnt) begin
`ifdef CLOCK_GATE_STATS_EN
            testsRun++;
            if (gated_cnt_o !== e.cnt) begin
                testsFailed++;
                $display("[TB] FAIL %s cyc %0d gated_cnt_o=%h expected %h", e.name, cyc, gated_cnt_o, e.cnt);
            end
`endif
        end else begin
            testsRun++;
            if (clk_o !== e.clk) begin
                testsFailed++;
                $display("[TB] FAIL %s cyc %0d clk_o=%b expected %b", e.name, cyc, clk_o, e.clk);
            end
            testsRun++;
            if (gated_o !== e.gated) begin
                testsFailed++;
                $display("[TB] FAIL %s cyc %0d gated_o=%b expected %b", e.name, cyc, gated_o, e.gated);
            end
            testsRun++;
            if (all_gated_o !== (&e.gated)) begin
                testsFailed++;
                $display("[TB] FAIL %s cyc %0d all_gated_o=%b expected %b", e.name, cyc, all_gated_o, &e.gated);
            end
        end
    endtask

    // Monitor: counts rising edges and pops every entry due this cycle.
    initial begin
        forever begin
            @(posedge clk_i);
            cyc++;
            #1;
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].cyc == cyc) begin
                    checkOutput(q[i]);
                    q.delete(i);
                end
            end
        end
    end

    // Stimulus with hand-computed expectations.
    initial begin
        applyStimulus(0, 1'b1, 4'b0000, 1'b0);
        expectAt(2, 4'b1111, 4'b0000, "reset_clk_runs");
        expectAt(3, 4'b1111, 4'b0000, "reset_clk_runs2");

        applyStimulus(3, 1'b0, 4'b0000, 1'b0);
        expectAt(11, 4'b1111, 4'b0000, "release_drain");
        expectAt(12, 4'b1111, 4'b1111, "release_last_pulse");
        expectAt(13, 4'b0000, 4'b1111, "release_stopped");

        applyStimulus(13, 1'b0, 4'b1111, 1'b0);
        expectAt(14, 4'b0000, 4'b0000, "wake_all_no_partial");
        expectAt(15, 4'b1111, 4'b0000, "wake_all_first_pulse");

        applyStimulus(20, 1'b0, 4'b1011, 1'b0);
        expectAt(28, 4'b1111, 4'b0000, "hyst_ch2_drain");
        expectAt(29, 4'b1111, 4'b0100, "hyst_ch2_last_pulse");
        expectAt(30, 4'b1011, 4'b0100, "hyst_ch2_stopped");

        applyStimulus(32, 1'b0, 4'b1010, 1'b0);
        applyStimulus(37, 1'b0, 4'b1011, 1'b0);
        applyStimulus(38, 1'b0, 4'b1010, 1'b0);
        expectAt(41, 4'b1011, 4'b0100, "rearm_not_gated_early");
        expectAt(46, 4'b1011, 4'b0100, "rearm_still_running");
        expectAt(47, 4'b1011, 4'b0101, "rearm_last_pulse");
        expectAt(48, 4'b1010, 4'b0101, "rearm_stopped");

        applyStimulus(48, 1'b0, 4'b0000, 1'b0);
        expectAt(56, 4'b1010, 4'b0101, "sleep13_drain");
        expectAt(57, 4'b1010, 4'b1111, "sleep13_all_gated");
        expectAt(58, 4'b0000, 4'b1111, "sleep13_stopped");

        applyStimulus(60, 1'b0, 4'b0010, 1'b0);
        expectAt(61, 4'b0000, 4'b1101, "wake1_no_partial");
        expectAt(62, 4'b0010, 4'b1101, "wake1_first_pulse");

        applyStimulus(64, 1'b0, 4'b0001, 1'b0);
        expectAt(65, 4'b0010, 4'b1100, "swap_edge");
        expectAt(66, 4'b0011, 4'b1100, "swap_both_run");
        expectAt(73, 4'b0011, 4'b1110, "swap_ch1_last_pulse");
        expectAt(74, 4'b0001, 4'b1110, "swap_ch1_stopped");

        applyStimulus(74, 1'b0, 4'b0000, 1'b0);
        expectAt(83, 4'b0001, 4'b1111, "sleep0_last_pulse");
        expectAt(84, 4'b0000, 4'b1111, "sleep0_stopped");

        applyStimulus(85, 1'b0, 4'b0000, 1'b1);
        expectAt(86, 4'b1111, 4'b1111, "test_en_open");
        expectAt(88, 4'b1111, 4'b1111, "test_en_open2");
        applyStimulus(88, 1'b0, 4'b0000, 1'b0);
        expectAt(89, 4'b0000, 4'b1111, "test_en_release");

        applyStimulus(90, 1'b1, 4'b0000, 1'b0);
        expectAt(91, 4'b0000, 4'b0000, "reset_from_gated");
        expectAt(92, 4'b1111, 4'b0000, "reset_from_gated_clk");
        applyStimulus(92, 1'b0, 4'b0000, 1'b0);
        applyStimulus(95, 1'b1, 4'b0000, 1'b0);
        applyStimulus(96, 1'b0, 4'b0000, 1'b0);
        expectAt(101, 4'b1111, 4'b0000, "reset_mid_drain");
        expectAt(104, 4'b1111, 4'b0000, "reset_mid_drain2");
        expectAt(105, 4'b1111, 4'b1111, "reset_mid_drain_gated");
        expectAt(106, 4'b0000, 4'b1111, "reset_mid_drain_stop");
        expectCnt(105, 4'h0, "stat_zero");
        expectCnt(106, 4'h1, "stat_one");
        expectCnt(110, 4'h5, "stat_five");
        expectCnt(120, 4'hF, "stat_full");
        expectCnt(125, 4'hF, "stat_saturated");

        applyStimulus(125, 1'b1, 4'b0000, 1'b0);
        expectAt(126, 4'b0000, 4'b0000, "final_reset");
        expectAt(127, 4'b1111, 4'b0000, "final_reset_clk");
        expectCnt(126, 4'h0, "stat_cleared");
        applyStimulus(128, 1'b0, 4'b0000, 1'b0);

        applyStimulus(131, 1'b0, 4'b0000, 1'b0);
        testsRun++;
        if (q.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL unconsumed_expectations pending=%0d expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #20000;
        testsFailed++;
        $display("[TB] FAIL watchdog cyc=%0d expected completion by 131", cyc);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
